// File: rtl/divide_num.sv
// ============================================================================
// Module   : divide_num
// Purpose  : Sequential unsigned N-bit divider (restoring shift-subtract),
//            one quotient bit per clock. A level-sensitive enable starts and
//            holds an operation; checkflag marks valid quotient/remainder.
// Options  : DIVIDE_NUM_ZERO_CHECK_EN - when defined, a zero divisor skips
//            the iteration loop and completes one edge after the start edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module divide_num #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         checkflag
);

    // Counter must be able to index iterations 0..N-1.
    localparam int            CW        = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [N-1:0]    dvd_q;      // working dividend, becomes the quotient
    logic [N-1:0]    dsr_q;      // divisor latched at the start edge
    logic [N:0]      prem_q;     // partial remainder, one bit wider than N
    logic [CW-1:0]   cnt_q;
    logic [N-1:0]    quot_q;
    logic [N-1:0]    rem_q;
    logic            flag_q;
`ifdef DIVIDE_NUM_ZERO_CHECK_EN
    logic            zero_q;     // divisor was zero at the start edge
`endif

    logic [N+1:0]    shifted;    // {partial remainder, dividend MSB}
    logic [N+1:0]    trial;      // shifted minus divisor, sign in MSB
    logic [N:0]      prem_d;
    logic [N-1:0]    dvd_d;

    // One restoring-division iteration: shift, trial subtract, restore or keep.
    // The shifted value is always below twice the divisor, so its top bit is
    // zero and the top bit of the difference is a true sign bit.
    always_comb begin
        shifted = {prem_q, dvd_q[N-1]};
        trial   = shifted - {2'b00, dsr_q};
        if (trial[N+1]) begin
            prem_d = shifted[N:0];
            dvd_d  = {dvd_q[N-2:0], 1'b0};
        end else begin
            prem_d = trial[N:0];
            dvd_d  = {dvd_q[N-2:0], 1'b1};
        end
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dsr_q   <= '0;
            prem_q  <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            flag_q  <= 1'b0;
`ifdef DIVIDE_NUM_ZERO_CHECK_EN
            zero_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        dvd_q   <= dividend;
                        dsr_q   <= divisor;
                        prem_q  <= '0;
                        cnt_q   <= '0;
`ifdef DIVIDE_NUM_ZERO_CHECK_EN
                        zero_q  <= (divisor == '0);
`endif
                        state_q <= BUSY;
                    end
                end

                BUSY: begin
                    if (!enable) begin
                        // Abort: results and flag stay as they were.
                        state_q <= IDLE;
`ifdef DIVIDE_NUM_ZERO_CHECK_EN
                    end else if (zero_q) begin
                        // Same answer the full loop would produce.
                        quot_q  <= '1;
                        rem_q   <= dvd_q;
                        flag_q  <= 1'b1;
                        state_q <= DONE;
`endif
                    end else begin
                        prem_q <= prem_d;
                        dvd_q  <= dvd_d;
                        cnt_q  <= cnt_q + CW'(1);
                        if (cnt_q == LAST_ITER) begin
                            quot_q  <= dvd_d;
                            rem_q   <= prem_d[N-1:0];
                            flag_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end

                DONE: begin
                    if (!enable) begin
                        flag_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign checkflag = flag_q;

endmodule

`default_nettype wire

// File: tb/tb_divide_num.sv
// ============================================================================
// Module   : tb_divide_num
// Purpose  : Directed self-checking bench for divide_num (N = 16).
//            Honours DIVIDE_NUM_ZERO_CHECK_EN for the divide-by-zero latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_divide_num;

    localparam int N = 16;
`ifdef DIVIDE_NUM_ZERO_CHECK_EN
    localparam int ZLAT = 2;
`else
    localparam int ZLAT = 17;
`endif

    logic         clk      = 1'b0;
    logic         reset    = 1'b1;
    logic         enable   = 1'b0;
    logic [N-1:0] dividend = '0;
    logic [N-1:0] divisor  = '0;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         checkflag;

    int tests = 0;
    int fails = 0;

    divide_num #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .checkflag (checkflag)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts an operation and returns the edge count (start edge = 1) at which
    // checkflag was seen high, or -1 if it never rose within the budget.
    // Inputs are scrambled after the start edge; the DUT must ignore that.
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, output int lat);
        dividend = a;
        divisor  = b;
        enable   = 1'b1;
        lat      = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 1) begin
                dividend = ~a;
                divisor  = b + 16'd3;
            end
            if (checkflag === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic drop_enable();
        enable = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        #2;
        reset    = 1'b0;
        enable   = 1'b1;
        dividend = 16'd57600;
        divisor  = 16'd150;
        #1;
        tests++; if (quotient !== 16'd0) begin fails++; $display("FAIL reset_q: got %0d expected 0", quotient); end
        tests++; if (remainder !== 16'd0) begin fails++; $display("FAIL reset_r: got %0d expected 0", remainder); end
        tests++; if (checkflag !== 1'b0) begin fails++; $display("FAIL reset_flag: got %b expected 0", checkflag); end
        repeat (20) tick();
        tests++; if (checkflag !== 1'b0) begin fails++; $display("FAIL reset_hold_flag: got %b expected 0", checkflag); end
        tests++; if (quotient !== 16'd0) begin fails++; $display("FAIL reset_hold_q: got %0d expected 0", quotient); end
        enable = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        tests++; if (checkflag !== 1'b0) begin fails++; $display("FAIL reset_release_flag: got %b expected 0", checkflag); end
    endtask

    task automatic test_basic();
        int lat;
        do_op(16'd57600, 16'd150, lat);
        tests++; if (lat !== 17) begin fails++; $display("FAIL basic_latency: got %0d expected 17", lat); end
        tests++; if (quotient !== 16'd384) begin fails++; $display("FAIL basic_q: got %0d expected 384", quotient); end
        tests++; if (remainder !== 16'd0) begin fails++; $display("FAIL basic_r: got %0d expected 0", remainder); end
        repeat (5) tick();
        tests++; if (checkflag !== 1'b1) begin fails++; $display("FAIL basic_hold_flag: got %b expected 1", checkflag); end
        tests++; if (quotient !== 16'd384) begin fails++; $display("FAIL basic_hold_q: got %0d expected 384", quotient); end
        drop_enable();
        tests++; if (checkflag !== 1'b0) begin fails++; $display("FAIL basic_drop_flag: got %b expected 0", checkflag); end
        tests++; if (quotient !== 16'd384) begin fails++; $display("FAIL basic_keep_q: got %0d expected 384", quotient); end
        tests++; if (remainder !== 16'd0) begin fails++; $display("FAIL basic_keep_r: got %0d expected 0", remainder); end
    endtask

    task automatic test_sequential();
        logic [N-1:0] va [4] = '{16'd100, 16'd7,  16'd65535, 16'd65535};
        logic [N-1:0] vb [4] = '{16'd5,   16'd10, 16'd1,     16'd65535};
        logic [N-1:0] eq [4] = '{16'd20,  16'd0,  16'd65535, 16'd1};
        logic [N-1:0] er [4] = '{16'd0,   16'd7,  16'd0,     16'd0};
        int lat;
        for (int k = 0; k < 4; k++) begin
            do_op(va[k], vb[k], lat);
            tests++; if (lat !== 17) begin fails++; $display("FAIL seq%0d_latency: got %0d expected 17", k, lat); end
            tests++; if (quotient !== eq[k]) begin fails++; $display("FAIL seq%0d_q: got %0d expected %0d", k, quotient, eq[k]); end
            tests++; if (remainder !== er[k]) begin fails++; $display("FAIL seq%0d_r: got %0d expected %0d", k, remainder, er[k]); end
            tests++; if (quotient !== va[k] / vb[k] || remainder !== va[k] % vb[k]) begin
                fails++; $display("FAIL seq%0d_model: got %0d r %0d expected %0d r %0d", k, quotient, remainder, va[k] / vb[k], va[k] % vb[k]);
            end
            drop_enable();
            tests++; if (checkflag !== 1'b0) begin fails++; $display("FAIL seq%0d_drop_flag: got %b expected 0", k, checkflag); end
        end
    endtask

    task automatic test_div_zero();
        int lat;
        do_op(16'd1000, 16'd0, lat);
        tests++; if (lat !== ZLAT) begin fails++; $display("FAIL divzero_latency: got %0d expected %0d", lat, ZLAT); end
        tests++; if (quotient !== 16'hFFFF) begin fails++; $display("FAIL divzero_q: got %h expected ffff", quotient); end
        tests++; if (remainder !== 16'd1000) begin fails++; $display("FAIL divzero_r: got %0d expected 1000", remainder); end
        drop_enable();
    endtask

    task automatic test_abort();
        int lat;
        dividend = 16'd57600;
        divisor  = 16'd150;
        enable   = 1'b1;
        repeat (7) tick();
        tests++; if (checkflag !== 1'b0) begin fails++; $display("FAIL abort_busy_flag: got %b expected 0", checkflag); end
        enable = 1'b0;
        tick();
        tests++; if (checkflag !== 1'b0) begin fails++; $display("FAIL abort_flag: got %b expected 0", checkflag); end
        tests++; if (quotient !== 16'hFFFF) begin fails++; $display("FAIL abort_q: got %h expected ffff", quotient); end
        tests++; if (remainder !== 16'd1000) begin fails++; $display("FAIL abort_r: got %0d expected 1000", remainder); end
        repeat (20) tick();
        tests++; if (checkflag !== 1'b0 || quotient !== 16'hFFFF) begin
            fails++; $display("FAIL abort_idle: got flag %b q %h expected flag 0 q ffff", checkflag, quotient);
        end
        do_op(16'd200, 16'd7, lat);
        tests++; if (lat !== 17) begin fails++; $display("FAIL restart_latency: got %0d expected 17", lat); end
        tests++; if (quotient !== 16'd28) begin fails++; $display("FAIL restart_q: got %0d expected 28", quotient); end
        tests++; if (remainder !== 16'd4) begin fails++; $display("FAIL restart_r: got %0d expected 4", remainder); end
        drop_enable();
    endtask

    task automatic test_reset_mid();
        int lat;
        dividend = 16'd57600;
        divisor  = 16'd150;
        enable   = 1'b1;
        repeat (10) tick();
        reset  = 1'b0;
        enable = 1'b0;
        #1;
        tests++; if (quotient !== 16'd0) begin fails++; $display("FAIL midreset_q: got %0d expected 0", quotient); end
        tests++; if (remainder !== 16'd0) begin fails++; $display("FAIL midreset_r: got %0d expected 0", remainder); end
        tests++; if (checkflag !== 1'b0) begin fails++; $display("FAIL midreset_flag: got %b expected 0", checkflag); end
        repeat (3) tick();
        reset = 1'b1;
        tick();
        tests++; if (checkflag !== 1'b0) begin fails++; $display("FAIL midreset_release_flag: got %b expected 0", checkflag); end
        do_op(16'd57600, 16'd150, lat);
        tests++; if (lat !== 17) begin fails++; $display("FAIL midreset_rerun_latency: got %0d expected 17", lat); end
        tests++; if (quotient !== 16'd384) begin fails++; $display("FAIL midreset_rerun_q: got %0d expected 384", quotient); end
        tests++; if (remainder !== 16'd0) begin fails++; $display("FAIL midreset_rerun_r: got %0d expected 0", remainder); end
        drop_enable();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sequential();
        test_div_zero();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/divide_num.md
# divide_num

Sequential unsigned integer divider: computes quotient and remainder of two N-bit operands using a restoring shift-subtract algorithm, one quotient bit per clock. Used wherever the datapath needs a low-area divide, for example normalising accumulated match scores. A level-sensitive `enable` starts an operation. `checkflag` signals that the results are valid.

## Interface
- `N`, default 16: operand and result width in bits; legal for N ≥ 2.

- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-low reset.
- `enable`  in  1: start/hold request. Level-sensitive.
- `dividend`  in  N: unsigned dividend. Sampled at start.
- `divisor`  in  N: unsigned divisor. Sampled at start.
- `quotient`  out  N: registered unsigned quotient.
- `remainder`  out  N: registered unsigned remainder.
- `checkflag`  out  1: result-valid flag.

## Operation
- States:
  - IDLE, BUSY and DONE.
  - On reset: state = IDLE, `quotient` = 0, `remainder` = 0, `checkflag` = 0, internal counter and registers cleared.
- IDLE:
  - If `enable` = 1 at a clock edge, latch `dividend`/`divisor` into internal registers.
  - Clear the working partial remainder (N+1 bits) and the bit counter.
  - Go to BUSY.
  - Otherwise hold all outputs.
- BUSY (restoring division, one iteration per edge):
  - Shift {partial remainder, working dividend} left by 1.
  - Trial-subtract the latched divisor from the partial remainder.
  - If the result is non-negative, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
  - Counter increments each iteration.
  - After the N-th iteration, load `quotient`/`remainder` from the working registers, set `checkflag` = 1 and go to DONE.
- DONE:
  - Outputs are held and `checkflag` stays 1 while `enable` = 1.
  - When `enable` = 0: go to IDLE and clear `checkflag`. `quotient`/`remainder` keep their last values.
- Abort:
  - `enable` = 0 during BUSY: go to IDLE.
  - Outputs are unchanged from their previous values and `checkflag` stays 0.
- Operands:
  - Input changes after the start edge are ignored until the next start.
  - A new operation requires `enable` to be low for at least one edge after DONE.
- Arithmetic:
  - Fully unsigned.
  - The partial remainder is N+1 bits wide so the trial subtraction never overflows.
  - Result identity: `dividend` = `quotient`·`divisor` + `remainder`, with `remainder` < `divisor` (for `divisor` ≠ 0).
- Divide by zero: `quotient` = all ones, `remainder` = `dividend`. This falls out naturally from the restoring algorithm.

## Timing
- Start edge: the first rising edge with `enable` = 1 in IDLE.
- `checkflag` rises, with valid results, at the (N+1)-th rising edge after and including the start edge. For N = 16, that is 17 edges.
- `checkflag` falls on the first edge at which `enable` = 0 is sampled in DONE.
- Asynchronous reset takes effect immediately, including mid-operation: outputs go to 0 and state to IDLE. Deassertion is synchronised by the system.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `DIVIDE_NUM_ZERO_CHECK_EN` defined:
  - At the start edge, a zero divisor bypasses BUSY.
  - At the next edge, `quotient` = all ones, `remainder` = `dividend` and `checkflag` = 1 (DONE). Latency is 2 edges.
- Not defined:
  - No special handling for a zero divisor. The normal N-iteration path runs.
  - Results are the same; latency is N+1 edges.

## Test plan
- Reset low with `enable` = 1 → `quotient` = 0, `remainder` = 0, `checkflag` = 0, and the state stays IDLE until reset is released.
- `enable` = 1, `dividend` = 57600, `divisor` = 150 (N = 16) → after 17 edges `checkflag` = 1, `quotient` = 384, `remainder` = 0. The flag holds while `enable` stays high.
- Sequential ops with `enable` dropped between them: 100/5 → 20 r 0; 7/10 → 0 r 7; 65535/1 → 65535 r 0; 65535/65535 → 1 r 0. Compare each against a reference model.
- 1000/0 → `quotient` = 0xFFFF, `remainder` = 1000. The flag rises after 2 edges with `DIVIDE_NUM_ZERO_CHECK_EN` defined, or after 17 edges without it.
- Abort by dropping `enable` at edge 8 → state returns to IDLE, `checkflag` = 0, outputs keep their prior values. Restarting then gives the correct result.
- Assert reset at edge 10 of an operation → outputs are immediately 0. Release reset, then a new 57600/150 run gives 384 r 0.
